// File: rtl/pid_incr_calc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pid_incr_calc                                                   |
// | Purpose  : Incremental-PID increment calculator. Computes                  |
// |            du(k) = Kp*(e(k)-e(k-1)) + Ki*e(k) + Kd*(e(k)-2e(k-1)+e(k-2))   |
// |            on one shared multiplier, then floor-scales and saturates.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pid_incr_calc #(
  parameter int ERR_W = 12,
  parameter int K_W   = 8,
  parameter int FRAC  = 4,
  parameter int OUT_W = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [ERR_W-1:0] setpoint,
  input  logic signed [ERR_W-1:0] feedback,
  input  logic        [K_W-1:0]   kp,
  input  logic        [K_W-1:0]   ki,
  input  logic        [K_W-1:0]   kd,
  input  logic                    clear_hist,
  output logic signed [OUT_W-1:0] d_uk,
  output logic                    d_uk_valid,
  output logic                    sat,
  output logic                    busy
);

  localparam int E_W   = ERR_W + 1;        // e(k): exact difference of two ERR_W values
  localparam int D1_W  = ERR_W + 2;        // e(k) - e(k-1)
  localparam int D2_W  = ERR_W + 3;        // e(k) - 2e(k-1) + e(k-2)
  localparam int G_W   = K_W + 1;          // gain zero-extended to signed
  localparam int P_W   = G_W + D2_W;       // widest product of the shared multiplier
  localparam int ACC_W = ERR_W + K_W + 6;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALC  = 3'd1;
  localparam logic [2:0] S_MUL_P = 3'd2;
  localparam logic [2:0] S_MUL_I = 3'd3;
  localparam logic [2:0] S_MUL_D = 3'd4;
  localparam logic [2:0] S_SAT   = 3'd5;

  logic        [2:0]       state_q, state_d;
  logic signed [E_W-1:0]   ek_q, ek_d, ek1_q, ek1_d, ek2_q, ek2_d;
  logic signed [D1_W-1:0]  de1_q, de1_d;
  logic signed [D2_W-1:0]  de2_q, de2_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [OUT_W-1:0] d_uk_q, d_uk_d;
  logic                    valid_q, valid_d;
  logic                    sat_q, sat_d;

  logic signed [E_W-1:0]   ek_new;
  logic signed [D1_W-1:0]  de1_new;
  logic signed [D2_W-1:0]  de2_new;
  logic        [K_W-1:0]   gain_sel;
  logic signed [G_W-1:0]   mul_a;
  logic signed [D2_W-1:0]  mul_b;
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] r_shift;
  logic        [ACC_W-OUT_W:0] r_hi;
  logic                    r_in_range;
  logic signed [OUT_W-1:0] r_clip;

  // Error arithmetic, multiplier operand selection and output clipping.
  always_comb begin
    ek_new  = {setpoint[ERR_W-1], setpoint} - {feedback[ERR_W-1], feedback};
    de1_new = {ek_q[E_W-1], ek_q} - {ek1_q[E_W-1], ek1_q};
    de2_new = {{2{ek_q[E_W-1]}}, ek_q} - {ek1_q[E_W-1], ek1_q, 1'b0}
            + {{2{ek2_q[E_W-1]}}, ek2_q};

    // One multiplier serves all three terms; the state picks gain and operand.
    case (state_q)
      S_MUL_I: begin
        gain_sel = ki;
        mul_b    = {{2{ek_q[E_W-1]}}, ek_q};
      end
      S_MUL_D: begin
        gain_sel = kd;
        mul_b    = de2_q;
      end
      default: begin
        gain_sel = kp;
        mul_b    = {de1_q[D1_W-1], de1_q};
      end
    endcase
    mul_a    = {1'b0, gain_sel};
    prod     = mul_a * mul_b;
    prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};

    // Arithmetic shift floors toward -inf; the result fits OUT_W only when
    // every bit from the OUT_W sign position upward is a copy of the sign.
    r_shift    = acc_q >>> FRAC;
    r_hi       = r_shift[ACC_W-1:OUT_W-1];
    r_in_range = (&r_hi) | ~(|r_hi);
    if (r_in_range) begin
      r_clip = r_shift[OUT_W-1:0];
    end else if (r_shift[ACC_W-1]) begin
      r_clip = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      r_clip = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  // State register and datapath registers; reset aborts any computation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ek_q    <= '0;
      ek1_q   <= '0;
      ek2_q   <= '0;
      de1_q   <= '0;
      de2_q   <= '0;
      acc_q   <= '0;
      d_uk_q  <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ek_q    <= ek_d;
      ek1_q   <= ek1_d;
      ek2_q   <= ek2_d;
      de1_q   <= de1_d;
      de2_q   <= de2_d;
      acc_q   <= acc_d;
      d_uk_q  <= d_uk_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
    end
  end

  // Next-state sequencing: a fixed six-cycle walk once a sample is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  state_d = S_MUL_P;
      S_MUL_P: state_d = S_MUL_I;
      S_MUL_I: state_d = S_MUL_D;
      S_MUL_D: state_d = S_SAT;
      S_SAT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values per state; the result registers default to zero so
  // the downstream accumulator sees a nonzero increment for one cycle only.
  always_comb begin
    ek_d    = ek_q;
    ek1_d   = ek1_q;
    ek2_d   = ek2_q;
    de1_d   = de1_q;
    de2_d   = de2_q;
    acc_d   = acc_q;
    d_uk_d  = '0;
    valid_d = 1'b0;
    sat_d   = 1'b0;
    case (state_q)
      S_IDLE:  if (start) ek_d = ek_new;
      S_CALC: begin
        de1_d = de1_new;
        de2_d = de2_new;
      end
      S_MUL_P: acc_d = prod_ext;
      S_MUL_I: acc_d = acc_q + prod_ext;
      S_MUL_D: acc_d = acc_q + prod_ext;
      S_SAT: begin
        d_uk_d  = r_clip;
        sat_d   = ~r_in_range;
        valid_d = 1'b1;
        ek2_d   = ek1_q;
        ek1_d   = ek_q;
      end
      default: ;
    endcase
    // Clearing history overrides the SAT-cycle shift; the in-flight result is
    // unaffected because the differences were captured in CALC.
    if (clear_hist) begin
      ek1_d = '0;
      ek2_d = '0;
    end
  end

  // Outputs come straight from registers; busy is a decode of the state register.
  always_comb begin
    d_uk       = d_uk_q;
    d_uk_valid = valid_q;
    sat        = sat_q;
    busy       = (state_q != S_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_pid_incr_calc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pid_incr_calc                                                |
// | Purpose  : Directed self-checking bench for pid_incr_calc.                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pid_incr_calc;
  localparam int ERR_W = 12;
  localparam int K_W   = 8;
  localparam int FRAC  = 4;
  localparam int OUT_W = 15;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start;
  logic signed [ERR_W-1:0] setpoint;
  logic signed [ERR_W-1:0] feedback;
  logic        [K_W-1:0]   kp, ki, kd;
  logic                    clear_hist;
  logic signed [OUT_W-1:0] d_uk;
  logic                    d_uk_valid;
  logic                    sat;
  logic                    busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pid_incr_calc #(
    .ERR_W(ERR_W), .K_W(K_W), .FRAC(FRAC), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .setpoint(setpoint), .feedback(feedback),
    .kp(kp), .ki(ki), .kd(kd), .clear_hist(clear_hist),
    .d_uk(d_uk), .d_uk_valid(d_uk_valid), .sat(sat), .busy(busy)
  );

  task automatic do_reset();
    rst_n      = 1'b0;
    start      = 1'b0;
    clear_hist = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives one sample and observes until the valid pulse (bounded).
  // lat = cycle offset of the pulse from the start cycle (-1 if none).
  // stray: a nonzero output or early pulse before it; busy_bad: busy wrong
  // in T+1..T+5 or high on the pulse; after_bad: outputs not zero after it.
  task automatic do_sample(input int sp, input int fb, input int clr_at,
                           output int lat, output int duk, output int s,
                           output bit stray, output bit busy_bad, output bit after_bad);
    lat = -1; duk = 0; s = 0; stray = 0; busy_bad = 0; after_bad = 0;
    @(negedge clk);
    setpoint = sp[ERR_W-1:0];
    feedback = fb[ERR_W-1:0];
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      clear_hist = (n == clr_at);
      if (d_uk_valid === 1'b1) begin
        lat = n;
        duk = int'(d_uk);
        s   = int'(sat);
        if (busy !== 1'b0) busy_bad = 1;
        break;
      end
      if (d_uk !== '0 || sat !== 1'b0 || d_uk_valid !== 1'b0) stray = 1;
      if (busy !== 1'b1) busy_bad = 1;
      @(negedge clk);
    end
    clear_hist = 1'b0;
    @(negedge clk);
    if (d_uk_valid !== 1'b0 || d_uk !== '0 || sat !== 1'b0) after_bad = 1;
  endtask

  task automatic test_reset();
    int lat, duk, s;
    bit st, bb, ab;
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start      = 1'($urandom);
      clear_hist = 1'($urandom);
      setpoint   = ERR_W'($urandom);
      feedback   = ERR_W'($urandom);
      kp = K_W'($urandom); ki = K_W'($urandom); kd = K_W'($urandom);
      #1;
      checks++;
      if (d_uk !== '0 || d_uk_valid !== 1'b0 || sat !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: d_uk=%0d valid=%b sat=%b busy=%b, required all 0",
                 i, d_uk, d_uk_valid, sat, busy);
      end
    end
    start = 1'b0; clear_hist = 1'b0;
    kp = 8'd16; ki = 8'd0; kd = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    do_sample(100, 0, 0, lat, duk, s, st, bb, ab);
    checks++;
    if (lat !== 6 || duk !== 100 || s !== 0 || st || bb || ab) begin
      errors++;
      $display("FAIL reset_first_sample: lat=%0d d_uk=%0d sat=%0d stray=%b busy_bad=%b after=%b, required lat=6 d_uk=100 sat=0",
               lat, duk, s, st, bb, ab);
    end
  endtask

  task automatic test_proportional();
    int sps[3] = '{100, 150, 40};
    int fbs[3] = '{0, 50, 0};
    int exp[3] = '{100, 0, -60};
    int lat, duk, s;
    bit st, bb, ab;
    do_reset();
    kp = 8'd16; ki = 8'd0; kd = 8'd0;
    for (int i = 0; i < 3; i++) begin
      do_sample(sps[i], fbs[i], 0, lat, duk, s, st, bb, ab);
      checks++;
      if (lat !== 6 || duk !== exp[i] || s !== 0 || st || bb || ab) begin
        errors++;
        $display("FAIL proportional[%0d]: lat=%0d d_uk=%0d sat=%0d stray=%b busy_bad=%b after=%b, required lat=6 d_uk=%0d sat=0",
                 i, lat, duk, s, st, bb, ab, exp[i]);
      end
    end
  endtask

  task automatic test_integral();
    int sps[3] = '{-50, -50, 0};
    int fbs[3] = '{0, 0, 1};
    int exp[3] = '{-50, -50, -1};
    int lat, duk, s;
    bit st, bb, ab;
    do_reset();
    kp = 8'd0; ki = 8'd16; kd = 8'd0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) ki = 8'd1;
      do_sample(sps[i], fbs[i], 0, lat, duk, s, st, bb, ab);
      checks++;
      if (lat !== 6 || duk !== exp[i] || s !== 0 || st || bb || ab) begin
        errors++;
        $display("FAIL integral[%0d]: lat=%0d d_uk=%0d sat=%0d stray=%b busy_bad=%b after=%b, required lat=6 d_uk=%0d sat=0",
                 i, lat, duk, s, st, bb, ab, exp[i]);
      end
    end
  endtask

  task automatic test_derivative();
    int exp_a[3] = '{10, -10, 0};
    int exp_b[3] = '{10, -10, 10};
    int lat, duk, s;
    bit st, bb, ab;
    // Second pass asserts clear_hist on the SAT edge of the second sample.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      kp = 8'd0; ki = 8'd0; kd = 8'd16;
      for (int i = 0; i < 3; i++) begin
        do_sample(10, 0, (pass == 1 && i == 1) ? 5 : 0, lat, duk, s, st, bb, ab);
        checks++;
        if (lat !== 6 || duk !== (pass == 0 ? exp_a[i] : exp_b[i]) || s !== 0 || st || bb || ab) begin
          errors++;
          $display("FAIL derivative pass%0d[%0d]: lat=%0d d_uk=%0d sat=%0d stray=%b busy_bad=%b after=%b, required lat=6 d_uk=%0d sat=0",
                   pass, i, lat, duk, s, st, bb, ab, pass == 0 ? exp_a[i] : exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int lat, duk, s;
    bit st, bb, ab;
    do_reset();
    kp = 8'd255; ki = 8'd0; kd = 8'd0;
    do_sample(2047, -2048, 0, lat, duk, s, st, bb, ab);
    checks++;
    if (lat !== 6 || duk !== 16383 || s !== 1 || st || bb || ab) begin
      errors++;
      $display("FAIL sat_positive: lat=%0d d_uk=%0d sat=%0d stray=%b busy_bad=%b after=%b, required lat=6 d_uk=16383 sat=1",
               lat, duk, s, st, bb, ab);
    end
    do_reset();
    do_sample(-2048, 2047, 0, lat, duk, s, st, bb, ab);
    checks++;
    if (lat !== 6 || duk !== -16384 || s !== 1 || st || bb || ab) begin
      errors++;
      $display("FAIL sat_negative: lat=%0d d_uk=%0d sat=%0d stray=%b busy_bad=%b after=%b, required lat=6 d_uk=-16384 sat=1",
               lat, duk, s, st, bb, ab);
    end
  endtask

  task automatic test_ignored_start();
    int pulses = 0;
    int first_pos = -1;
    int first_val = 0;
    do_reset();
    kp = 8'd16; ki = 8'd0; kd = 8'd0;
    @(negedge clk);
    setpoint = 12'sd20; feedback = 12'sd0; start = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 2) begin start = 1'b1; setpoint = 12'sd500; end
      if (n == 3) start = 1'b0;
      if (d_uk_valid === 1'b1) begin
        pulses++;
        if (first_pos < 0) begin first_pos = n; first_val = int'(d_uk); end
      end
    end
    checks++;
    if (pulses !== 1 || first_pos !== 6 || first_val !== 20) begin
      errors++;
      $display("FAIL start_while_busy: pulses=%0d first_at=T+%0d d_uk=%0d, required pulses=1 at T+6 d_uk=20",
               pulses, first_pos, first_val);
    end
  endtask

  task automatic test_back_to_back();
    int pos[$];
    int vals[$];
    bit gap_bad = 0;
    do_reset();
    kp = 8'd16; ki = 8'd0; kd = 8'd0;
    @(negedge clk);
    setpoint = 12'sd30; feedback = 12'sd0; start = 1'b1;
    for (int n = 1; n <= 26; n++) begin
      @(negedge clk);
      if (d_uk_valid === 1'b1) begin
        pos.push_back(n);
        vals.push_back(int'(d_uk));
      end
    end
    start = 1'b0;
    for (int i = 0; i < pos.size(); i++)
      if (pos[i] !== 6 * (i + 1)) gap_bad = 1;
    checks++;
    if (pos.size() !== 4 || gap_bad) begin
      errors++;
      $display("FAIL back_to_back_timing: pulses=%0d gap_bad=%b, required 4 pulses at T+6,12,18,24",
               pos.size(), gap_bad);
    end
    checks++;
    if (vals.size() < 2 || vals[0] !== 30 || vals[1] !== 0) begin
      errors++;
      $display("FAIL back_to_back_values: count=%0d first=%0d second=%0d, required 30 then 0",
               vals.size(), vals.size() > 0 ? vals[0] : 0, vals.size() > 1 ? vals[1] : 0);
    end
  endtask

  task automatic test_abort();
    int pulses = 0;
    bit out_bad = 0;
    do_reset();
    kp = 8'd16; ki = 8'd0; kd = 8'd0;
    @(negedge clk);
    setpoint = 12'sd77; feedback = 12'sd0; start = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 3) begin
        rst_n = 1'b0;
        #1;
        if (d_uk !== '0 || d_uk_valid !== 1'b0 || sat !== 1'b0 || busy !== 1'b0) out_bad = 1;
      end
      if (n == 4) rst_n = 1'b1;
      if (n > 3 && (d_uk !== '0 || sat !== 1'b0 || busy !== 1'b0)) out_bad = 1;
      if (d_uk_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0 || out_bad) begin
      errors++;
      $display("FAIL abort: pulses=%0d outputs_nonzero=%b, required pulses=0 outputs 0", pulses, out_bad);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clear_hist = 1'b0;
    setpoint = '0; feedback = '0; kp = '0; ki = '0; kd = '0;
    test_reset();
    test_proportional();
    test_integral();
    test_derivative();
    test_saturation();
    test_ignored_start();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
